// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns a stream of 32-bit big-endian message words into
// padded 512-bit blocks (data, 0x80 marker, zero fill, 64-bit bit length).
module sha256_padder (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  input  logic [2:0]  in_nbytes,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_block_start,
  output logic        out_block_end,
  output logic        out_msg_end,
  output logic [63:0] msg_len_o
);

  typedef enum logic [2:0] {DATA, MARK, ZERO, LEN_HI, LEN_LO} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_idx;
  logic [63:0] r_len;
  logic [63:0] w_len_nxt;
  logic [3:0]  w_idx_nxt;
  logic [2:0]  w_nb;
  logic [31:0] w_word;
  logic [31:0] w_marked;
  logic        w_avail;
  logic        w_can_load;
  logic        w_load;

  assign w_can_load = !out_valid || out_ready;
  assign w_idx_nxt  = r_idx + 4'd1;
  assign w_nb       = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
  assign w_load     = w_avail && w_can_load;

  // Keep the valid leading bytes and place the 0x80 marker right after them.
  always_comb begin
    w_marked = in_data;
    case (w_nb)
      3'd0:    w_marked = 32'h8000_0000;
      3'd1:    w_marked = {in_data[31:24], 24'h80_0000};
      3'd2:    w_marked = {in_data[31:16], 16'h8000};
      3'd3:    w_marked = {in_data[31:8],  8'h80};
      default: w_marked = in_data;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_avail     = 1'b0;
    w_word      = '0;
    w_len_nxt   = r_len;
    in_ready    = (r_state == DATA) && w_can_load;
    case (r_state)
      DATA: begin
        w_avail = in_valid;
        w_word  = in_data;
        if (in_last) begin
          w_len_nxt = r_len + {58'd0, w_nb, 3'd0};
          if (w_nb == 3'd4) begin
            w_state_nxt = MARK;
          end else begin
            w_word      = w_marked;
            w_state_nxt = (w_idx_nxt == 4'd14) ? LEN_HI : ZERO;
          end
        end else begin
          w_len_nxt = r_len + 64'd32;
        end
      end
      MARK: begin
        w_avail     = 1'b1;
        w_word      = 32'h8000_0000;
        w_state_nxt = (w_idx_nxt == 4'd14) ? LEN_HI : ZERO;
      end
      ZERO: begin
        w_avail = 1'b1;
        if (w_idx_nxt == 4'd14) w_state_nxt = LEN_HI;
      end
      LEN_HI: begin
        w_avail     = 1'b1;
        w_word      = r_len[63:32];
        w_state_nxt = LEN_LO;
      end
      LEN_LO: begin
        w_avail     = 1'b1;
        w_word      = r_len[31:0];
        w_state_nxt = DATA;
      end
      default: w_state_nxt = DATA;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= DATA;
    end else if (w_load) begin
      r_state <= w_state_nxt;
    end
  end

  // Flags are latched with the word so they stay aligned while the output is stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx           <= '0;
      r_len           <= '0;
      out_valid       <= 1'b0;
      out_word        <= '0;
      out_block_start <= 1'b0;
      out_block_end   <= 1'b0;
      out_msg_end     <= 1'b0;
      msg_len_o       <= '0;
    end else if (w_load) begin
      out_valid       <= 1'b1;
      out_word        <= w_word;
      out_block_start <= (r_idx == 4'd0);
      out_block_end   <= (r_idx == 4'd15);
      out_msg_end     <= (r_state == LEN_LO);
      if (r_state == LEN_LO) begin
        msg_len_o <= r_len;
        r_len     <= '0;
        r_idx     <= '0;
      end else begin
        r_len <= w_len_nxt;
        r_idx <= w_idx_nxt;
      end
    end else if (out_ready) begin
      out_valid       <= 1'b0;
      out_block_start <= 1'b0;
      out_block_end   <= 1'b0;
      out_msg_end     <= 1'b0;
    end
  end

endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
- REQ-001 SHALL have port CLK, input, 1, rising-edge clock.
- REQ-002 SHALL have port RST, input, 1, asynchronous active-high reset.
- REQ-003 SHALL have port in_valid, input, 1, source word valid.
- REQ-004 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
- REQ-005 SHALL have port in_data, input, 32, message word, big-endian byte order (byte 0 = bits 31:24).
- REQ-006 SHALL have port in_last, input, 1, final word of message.
- REQ-007 SHALL have port in_nbytes, input, 3, valid bytes in final word (0..4), sampled only with in_last.
- REQ-008 SHALL have port out_valid, output, 1, out_word valid.
- REQ-009 SHALL have port out_ready, input, 1, downstream accepts out_word.
- REQ-010 SHALL have port out_word, output, 32, padded block word W[idx].
- REQ-011 SHALL have port out_block_start, output, 1, high with out_valid when out_word is word 0 of a block.
- REQ-012 SHALL have port out_block_end, output, 1, high with out_valid when out_word is word 15 of a block.
- REQ-013 SHALL have port out_msg_end, output, 1, high with out_valid on the final length word of a message.
- REQ-014 SHALL have port msg_len_o, output, 64, message bit length, feeds the downstream 64-bit length register.

Function
- REQ-015 SHALL use a single registered output stage; transfer = valid & ready on each side; latency input-accept to out_valid = 1 cycle.
- REQ-016 Output register SHALL load when !out_valid | out_ready and a word is available; out_word and out_valid SHALL hold while out_valid & !out_ready.
- REQ-017 in_ready SHALL be (state==DATA) & (!out_valid | out_ready); in_ready SHALL be 0 in all other states.
- REQ-018 SHALL implement states DATA, MARK, ZERO, LEN_HI, LEN_LO; reset state DATA.
- REQ-019 SHALL keep a 4-bit word index idx, incremented per output-register load, wrapping 15->0; flags derived from idx of the loaded word.
- REQ-020 SHALL keep a 64-bit bit counter len, +32 per non-last accepted word, +8*in_nbytes on the last word, modulo 2^64.
- REQ-021 DATA, non-last word: out_word = in_data; stay DATA.
- REQ-022 DATA, last word, in_nbytes 0..3: out_word = top in_nbytes bytes of in_data, byte in_nbytes = 0x80, remaining bytes 0; next ZERO, or LEN_HI if next idx == 14.
- REQ-023 DATA, last word, in_nbytes 4: out_word = in_data; next MARK.
- REQ-024 MARK: out_word = 0x80000000; next ZERO, or LEN_HI if next idx == 14.
- REQ-025 ZERO: out_word = 0; leave to LEN_HI when next idx == 14; marker at idx 14 or 15 therefore SHALL produce a second block.
- REQ-026 LEN_HI: out_word = len[63:32]; LEN_LO: out_word = len[31:0], out_msg_end = 1, msg_len_o <= len, then len <= 0, idx = 0, state DATA.
- REQ-027 msg_len_o SHALL hold until the next LEN_LO load.
- REQ-028 in_nbytes > 4 with in_last SHALL be treated as 4.

Reset
- REQ-029 RST high SHALL immediately force state DATA, idx 0, len 0, out_valid 0, out_word 0, all flags 0, msg_len_o 0, regardless of CLK, including mid-message.
- REQ-030 After RST release, the first accepted word SHALL be word 0 of a new message.

Verification
- REQ-031 Empty message (in_last, nbytes 0) -> 0x80000000, 13x 0, 0x00000000, 0x00000000; start on word 0, end+msg_end on word 15; msg_len_o = 0.
- REQ-032 "abc" (0x61626300, last, nbytes 3) -> 0x61626380, 13x 0, 0, 0x00000018; msg_len_o = 24.
- REQ-033 13 full words + last 0xAABBCC00 nbytes 3 -> word 13 = 0xAABBCC80, words 14/15 = 0, 0x000001B8; single block.
- REQ-034 14 words, last nbytes 4 -> word 14 = 0x80000000, word 15 = 0, block 2 = 14x 0, 0, 0x000001C0; two block_start, two block_end, one msg_end.
- REQ-035 out_ready low 3 cycles mid-message -> out_word/out_valid stable, in_ready 0, no word lost or duplicated.
- REQ-036 RST pulse while in ZERO -> outputs 0 at once; following "abc" message yields exactly the REQ-032 sequence.
